// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx serialiser between two
// show-ahead TX FIFOs (channel 0 = ZiFi, channel 1 = RS232).
//
// Optional feature macro: UART_TX_ARB_BURST_EN. When defined, a channel may send
// up to BURST consecutive bytes while the other channel is requesting. When not
// defined, the burst counter does not exist and the arbiter alternates per byte
// whenever both channels request, which is the same as BURST = 1.
//
// Handshake: a request is en[n] & ~chn_empty. The arbiter answers a request with a
// single-cycle chN_rdreq pulse and a single-cycle tx_dv pulse on the same cycle,
// with tx_byte already holding the popped head byte. It then waits for uart_tx to
// raise tx_active, then for the tx_done pulse, and spends one GAP cycle so that
// the FIFO empty flag settles before the next arbitration. tx_done outside
// WAIT_DONE is ignored. All outputs are registered.
module uart_tx_arb #(
  parameter int unsigned BURST = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] en,
  input  logic       ch0_empty,
  input  logic [7:0] ch0_q,
  output logic       ch0_rdreq,
  input  logic       ch1_empty,
  input  logic [7:0] ch1_q,
  output logic       ch1_rdreq,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       grant,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] req;
  logic       own_req, other_req, keep, sel;
  logic       dv_nxt, rd0_nxt, rd1_nxt, grant_nxt, busy_nxt;
  logic [7:0] byte_nxt;

  assign req       = en & {~ch1_empty, ~ch0_empty};
  assign own_req   = grant ? req[1] : req[0];
  assign other_req = grant ? req[0] : req[1];
  // keep = stay on the current owner; otherwise hand over to the other channel.
  assign sel       = keep ? grant : ~grant;

`ifdef UART_TX_ARB_BURST_EN
  localparam logic [7:0] BURST_W = 8'(BURST);

  logic [7:0] cnt, cnt_nxt;

  // cnt == 0 marks a fresh arbitration (after reset or an idle cycle): the other
  // channel is preferred, so simultaneous first requests after reset go to ch0.
  assign keep = own_req && (((cnt != 8'd0) && (cnt < BURST_W)) || !other_req);

  // Burst counter: cleared on a switch or an idle cycle, counts completed characters.
  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE) begin
      if (!keep) cnt_nxt = 8'd0;
    end else if ((state == WAIT_DONE) && tx_done && (cnt < BURST_W)) begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 8'd0;
    else        cnt <= cnt_nxt;
  end
`else
  logic unused_burst;

  // Strict per-byte alternation whenever both channels request.
  assign keep = own_req && !other_req;
  // BURST has no effect in this build; the reduction only keeps it referenced.
  assign unused_burst = ^BURST;
`endif

  // Next state and next registered outputs; everything defaults to hold/idle.
  always_comb begin
    state_nxt = state;
    dv_nxt    = 1'b0;
    rd0_nxt   = 1'b0;
    rd1_nxt   = 1'b0;
    grant_nxt = grant;
    byte_nxt  = tx_byte;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = START;
          dv_nxt    = 1'b1;
          rd0_nxt   = ~sel;
          rd1_nxt   = sel;
          grant_nxt = sel;
          byte_nxt  = sel ? ch1_q : ch0_q;
        end
      end
      START:     state_nxt = WAIT_ACT;
      WAIT_ACT:  if (tx_active) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_nxt = GAP;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dv     <= 1'b0;
      ch0_rdreq <= 1'b0;
      ch1_rdreq <= 1'b0;
      tx_byte   <= 8'h00;
      grant     <= 1'b1;
      busy      <= 1'b0;
    end else begin
      tx_dv     <= dv_nxt;
      ch0_rdreq <= rd0_nxt;
      ch1_rdreq <= rd1_nxt;
      tx_byte   <= byte_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single 115200-baud `uart_tx` serialiser between two byte sources, the ZiFi output FIFO (channel 0) and the RS232 output FIFO (channel 1). It sits between the two show-ahead TX FIFOs and `uart_tx` in the ZiFi peripheral.

It pops exactly one byte per transmitted character and sequences the `uart_tx` DV/active/done handshake. It bounds the burst length of each channel so that neither source can starve the other.

## Interface
- `BURST`, 16: maximum consecutive bytes a channel may send while the other channel is requesting; legal range 1..255.
- `clk`  in  1  system clock (28 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  2  per-channel enable; bit n gates channel n requests.
- `ch0_empty`  in  1  channel 0 FIFO empty.
- `ch0_q`  in  8  channel 0 FIFO head byte (show-ahead).
- `ch0_rdreq`  out  1  channel 0 pop strobe, 1-cycle pulse.
- `ch1_empty`  in  1  channel 1 FIFO empty.
- `ch1_q`  in  8  channel 1 FIFO head byte (show-ahead).
- `ch1_rdreq`  out  1  channel 1 pop strobe, 1-cycle pulse.
- `tx_dv`  out  1  start strobe to `uart_tx`, 1-cycle pulse.
- `tx_byte`  out  8  byte to `uart_tx`; held stable until `tx_done`.
- `tx_active`  in  1  `uart_tx` busy.
- `tx_done`  in  1  `uart_tx` character-complete pulse.
- `grant`  out  1  channel currently owning, or last owning, the UART.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Request: `req[n] = en[n] & ~chn_empty`.
- States:
  - IDLE: wait for a request.
  - START: a 1-cycle strobe state.
  - WAIT_ACT: wait for `tx_active` = 1.
  - WAIT_DONE: wait for `tx_done`.
  - GAP: one cycle that lets the FIFO `empty` flag settle after a pop.
- IDLE, on any request:
  - Selected channel `sel` = `~grant` if `req[~grant]`, else the requesting channel.
  - Register `tx_byte <= chsel_q`.
  - Pulse `tx_dv` and `chsel_rdreq` for 1 cycle.
  - `grant <= sel`; go to START.
- START → WAIT_ACT unconditionally.
- WAIT_ACT → WAIT_DONE when `tx_active` = 1.
- WAIT_DONE → GAP on `tx_done`; burst counter `cnt` increments, saturating at `BURST`.
- GAP → IDLE. Arbitration in IDLE uses `cnt`:
  - If `req[grant]` and (`cnt < BURST` or `~req[~grant]`): same channel again, `cnt` keeps counting.
  - Else if `req[~grant]`: switch channels, `cnt <= 0`.
  - No request: `cnt <= 0`, stay IDLE.
- Simultaneous first requests from reset: channel 0 wins, because `grant` resets to 1.
- `en[n]` dropped mid-character: the current byte completes; no further pops from channel n.
- `en[n]` does not abort the UART. A `tx_done` seen outside WAIT_DONE is ignored.
- `chn_empty` rising while in START/WAIT_*: no effect. The pop was already issued while the FIFO was non-empty.
- Exactly one `rdreq` pulse per `tx_dv` pulse, on the same cycle. Never both `rdreq` outputs together.

## Timing
- Reset values:
  - State IDLE.
  - `tx_dv`, `ch0_rdreq`, `ch1_rdreq`, `busy` = 0.
  - `tx_byte` = 8'h00.
  - `grant` = 1.
  - `cnt` = 0.
- All outputs are registered.
- Request latency: a request sampled at edge N gives `tx_dv`/`rdreq` high during cycle N+1.
- `busy` rises on the same edge as `tx_dv`, i.e. visible in cycle N+1.
- `tx_byte` is valid from the `tx_dv` cycle until the cycle after `tx_done`.
- Back-to-back bytes: next `tx_dv` comes 2 cycles after the `tx_done` cycle (GAP + IDLE).
- Character period ≈ 10×243 + 2 cycles.
- Reset asserted mid-character: all outputs clear immediately, and the popped byte is lost. The FIFOs are cleared by the same reset upstream.

## Configuration
- `UART_TX_ARB_BURST_EN` defined: `BURST` limit applies as described.
- Not defined: `cnt` logic is removed and behaviour equals `BURST` = 1. The arbiter strictly alternates per byte whenever both channels request.

## Test plan
- Reset, only ch0 non-empty with 3 bytes 0x41,0x42,0x43, `en`=2'b11:
  - `tx_byte` sequence 0x41,0x42,0x43.
  - 3 `ch0_rdreq` pulses, 0 on ch1.
  - `grant`=0 throughout.
- Both channels hold 20 bytes, `BURST`=16, macro defined:
  - 16 ch0 bytes, then 16 ch1 bytes, then 4 ch0, then 4 ch1.
  - `cnt` resets at each switch.
- Same stimulus with macro undefined: strict alternation ch0,ch1,ch0,… for 40 bytes.
- Drop `en[0]` during WAIT_DONE of ch0 byte 5 while ch0 holds 10 bytes and ch1 is empty:
  - Byte 5 completes, `busy` falls.
  - No further `ch0_rdreq`.
  - Resumes when `en[0]` returns.
- `tx_active` withheld for 50 cycles after `tx_dv`: the block stays in WAIT_ACT, with no second `tx_dv` and no extra `rdreq`.
- Assert `rst_n`=0 during WAIT_DONE:
  - Outputs return to reset values asynchronously.
  - After release with ch1 non-empty, the first `tx_dv` comes 2 edges later with `grant`=1.
